// File: rtl/waveform_clock_ctrl.sv
// Run/stop and glitch-free prescaler update controller for a two-channel waveform clock generator.
// Optional update timeout is enabled by defining WC_CTRL_TIMEOUT_EN.
module waveform_clock_ctrl #(
  parameter int unsigned PSC_W = 16,
  parameter int unsigned TMO_W = 20
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic             cfg_ch_i,
  input  logic [PSC_W-1:0] cfg_psc_i,
  output logic             cfg_err_o,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             wc_clk_1_i,
  input  logic             wc_clk_2_i,
  output logic [PSC_W-1:0] wc_psc_1_o,
  output logic [PSC_W-1:0] wc_psc_2_o,
  output logic             wc_en_o,
  output logic             wc_rst_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t           state, state_d;
  logic             ready_q, ready_d, err_d, en_d, wrst_d, busy_d;
  logic [PSC_W-1:0] psc1_d, psc2_d, shd1_q, shd1_d, shd2_q, shd2_d;
  logic             pend1_q, pend1_d, pend2_q, pend2_d;
  logic             clk1_q, clk2_q;
  logic             acc, legal, wr1, wr2, fall1, fall2, tmo1, tmo2, apply1, apply2;

  function automatic logic legal_psc(input logic [PSC_W-1:0] v);
    return !v[0] && (v >= PSC_W'(4));
  endfunction

  // Writes are refused on any cycle carrying a stop command.
  assign cfg_ready_o = ready_q & ~stop_i;

  assign acc    = cfg_valid_i & cfg_ready_o;
  assign legal  = legal_psc(cfg_psc_i);
  assign wr1    = acc & legal & ~cfg_ch_i;
  assign wr2    = acc & legal & cfg_ch_i;
  assign fall1  = clk1_q & ~wc_clk_1_i;
  assign fall2  = clk2_q & ~wc_clk_2_i;
  assign apply1 = pend1_q & (fall1 | tmo1);
  assign apply2 = pend2_q & (fall2 | tmo2);

`ifdef WC_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] cnt1_q, cnt2_q;

  assign tmo1 = pend1_q & ~fall1 & (cnt1_q == '1);
  assign tmo2 = pend2_q & ~fall2 & (cnt2_q == '1);

  // Timeout counters restart whenever a channel is reloaded or leaves pending.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= (!pend1_d || wr1 || apply1) ? '0 : cnt1_q + TMO_W'(1);
      cnt2_q <= (!pend2_d || wr2 || apply2) ? '0 : cnt2_q + TMO_W'(1);
    end
  end
`else
  logic [TMO_W-1:0] tmo_w_unused;
  assign tmo_w_unused = '0;
  assign tmo1 = 1'b0;
  assign tmo2 = 1'b0;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    en_d    = 1'b0;
    wrst_d  = 1'b1;
    err_d   = acc & ~legal;
    psc1_d  = wc_psc_1_o;
    psc2_d  = wc_psc_2_o;
    shd1_d  = shd1_q;
    shd2_d  = shd2_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    case (state)
      IDLE: begin
        if (wr1) psc1_d = cfg_psc_i;
        if (wr2) psc2_d = cfg_psc_i;
        if (start_i && !stop_i) begin
          if (legal_psc(wc_psc_1_o) && legal_psc(wc_psc_2_o)) begin
            state_d = ALIGN;
            wrst_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ALIGN: begin
        if (stop_i) begin
          state_d = IDLE;
          wrst_d  = 1'b0;
        end else begin
          state_d = RUN;
          en_d    = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          wrst_d  = 1'b0;
          pend1_d = 1'b0;
          pend2_d = 1'b0;
        end else begin
          en_d = 1'b1;
          // Apply the old shadow first; a same-cycle write then re-arms the channel.
          if (apply1) begin
            psc1_d  = shd1_q;
            pend1_d = 1'b0;
          end
          if (apply2) begin
            psc2_d  = shd2_q;
            pend2_d = 1'b0;
          end
          if (wr1) begin
            shd1_d  = cfg_psc_i;
            pend1_d = 1'b1;
          end
          if (wr2) begin
            shd2_d  = cfg_psc_i;
            pend2_d = 1'b1;
          end
          if (tmo1 || tmo2) begin
            wrst_d = 1'b0;
            err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == RUN);
    busy_d  = pend1_d | pend2_d;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      ready_q    <= 1'b0;
      cfg_err_o  <= 1'b0;
      wc_en_o    <= 1'b0;
      wc_rst_o   <= 1'b0;
      busy_o     <= 1'b0;
      wc_psc_1_o <= '0;
      wc_psc_2_o <= '0;
      shd1_q     <= '0;
      shd2_q     <= '0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      cfg_err_o  <= err_d;
      wc_en_o    <= en_d;
      wc_rst_o   <= wrst_d;
      busy_o     <= busy_d;
      wc_psc_1_o <= psc1_d;
      wc_psc_2_o <= psc2_d;
      shd1_q     <= shd1_d;
      shd2_q     <= shd2_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      clk1_q     <= wc_clk_1_i;
      clk2_q     <= wc_clk_2_i;
    end
  end

endmodule

// File: tb/tb_waveform_clock_ctrl.sv
// Directed self-checking bench for waveform_clock_ctrl; covers the timeout path when WC_CTRL_TIMEOUT_EN is defined.
module tb_waveform_clock_ctrl;

  localparam int unsigned PSC_W = 16;
`ifdef WC_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
`else
  localparam int unsigned TMO_W = 20;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid, cfg_ready, cfg_ch, cfg_err;
  logic [PSC_W-1:0] cfg_psc, psc1, psc2;
  logic             start, stop, wclk1, wclk2, en, wrst, busy;

  int checks   = 0;
  int failures = 0;

  waveform_clock_ctrl #(.PSC_W(PSC_W), .TMO_W(TMO_W)) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst_n),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i   (cfg_ch),
    .cfg_psc_i  (cfg_psc),
    .cfg_err_o  (cfg_err),
    .start_i    (start),
    .stop_i     (stop),
    .wc_clk_1_i (wclk1),
    .wc_clk_2_i (wclk2),
    .wc_psc_1_o (psc1),
    .wc_psc_2_o (psc2),
    .wc_en_o    (en),
    .wc_rst_o   (wrst),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic ch, input logic [PSC_W-1:0] v);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_psc   = v;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_psc = '0;
    start = 1'b0; stop = 1'b0; wclk1 = 1'b0; wclk2 = 1'b0;
    tick(); tick();
    check("rst_en", 32'(en), 0);
    check("rst_wrst", 32'(wrst), 0);
    check("rst_psc1", 32'(psc1), 0);
    check("rst_psc2", 32'(psc2), 0);
    check("rst_ready", 32'(cfg_ready), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_busy", 32'(busy), 0);

    rst_n = 1'b1;
    tick();
    check("rel_wrst", 32'(wrst), 1);
    check("rel_ready", 32'(cfg_ready), 1);

    // Illegal values rejected, start refused while prescalers are illegal.
    write(1'b1, 16'd7);
    check("odd_err", 32'(cfg_err), 1);
    check("odd_psc2", 32'(psc2), 0);
    tick();
    check("err_clear", 32'(cfg_err), 0);
    write(1'b0, 16'd2);
    check("small_err", 32'(cfg_err), 1);
    check("small_psc1", 32'(psc1), 0);
    pulse_start();
    check("badstart_err", 32'(cfg_err), 1);
    check("badstart_wrst", 32'(wrst), 1);
    check("badstart_en", 32'(en), 0);

    // Legal writes in IDLE, including the boundary value 4.
    write(1'b0, 16'd4);
    check("min_psc1", 32'(psc1), 4);
    check("min_err", 32'(cfg_err), 0);
    write(1'b0, 16'd8);
    check("w8_psc1", 32'(psc1), 8);
    write(1'b1, 16'd12);
    check("w12_psc2", 32'(psc2), 12);
    check("w12_err", 32'(cfg_err), 0);

    // stop alone in IDLE has no effect; ready drops while stop is high.
    stop = 1'b1;
    #1;
    check("stop_ready", 32'(cfg_ready), 0);
    tick();
    stop = 1'b0;
    check("idle_stop_wrst", 32'(wrst), 1);
    check("idle_stop_en", 32'(en), 0);

    // Start: one ALIGN cycle with reset low, then RUN.
    pulse_start();
    check("align_wrst", 32'(wrst), 0);
    check("align_en", 32'(en), 0);
    check("align_ready", 32'(cfg_ready), 0);
    tick();
    check("run_wrst", 32'(wrst), 1);
    check("run_en", 32'(en), 1);
    check("run_ready", 32'(cfg_ready), 1);
    pulse_start();
    check("rerun_wrst", 32'(wrst), 1);
    check("rerun_en", 32'(en), 1);

    // Pending update discarded by stop+start.
    write(1'b0, 16'd20);
    check("pend_busy", 32'(busy), 1);
    check("pend_psc1", 32'(psc1), 8);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stop_en", 32'(en), 0);
    check("stop_wrst", 32'(wrst), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_psc1", 32'(psc1), 8);
    wclk1 = 1'b1;
    tick();
    check("stop_wrst_once", 32'(wrst), 1);
    wclk1 = 1'b0;
    tick(); tick();
    check("stop_noapply", 32'(psc1), 8);

    pulse_start();
    tick();
    check("rerun2_en", 32'(en), 1);

    // Update applied only after a falling edge on the channel's clock.
    write(1'b0, 16'd16);
    check("u16_busy", 32'(busy), 1);
    wclk1 = 1'b1;
    tick();
    check("u16_hold", 32'(psc1), 8);
    wclk1 = 1'b0;
    tick();
    check("u16_apply", 32'(psc1), 16);
    check("u16_busy_clr", 32'(busy), 0);

    // Last write wins on channel 2.
    write(1'b1, 16'd20);
    write(1'b1, 16'd24);
    wclk2 = 1'b1;
    tick();
    check("lww_hold", 32'(psc2), 12);
    wclk2 = 1'b0;
    tick();
    check("lww_apply", 32'(psc2), 24);
    check("lww_busy", 32'(busy), 0);

    // Write coincident with the falling edge: old shadow applied, new one pending.
    write(1'b0, 16'd32);
    wclk1 = 1'b1;
    tick();
    wclk1 = 1'b0;
    write(1'b0, 16'd40);
    check("coinc_psc1", 32'(psc1), 32);
    check("coinc_busy", 32'(busy), 1);
    wclk1 = 1'b1;
    tick();
    wclk1 = 1'b0;
    tick();
    check("coinc_psc1b", 32'(psc1), 40);
    check("coinc_busy_clr", 32'(busy), 0);

    // Illegal write in RUN.
    write(1'b1, 16'd9);
    check("run_bad_err", 32'(cfg_err), 1);
    check("run_bad_busy", 32'(busy), 0);

`ifdef WC_CTRL_TIMEOUT_EN
    begin
      int n = 0;
      int rst_lo = 0;
      int errs = 0;
      wclk1 = 1'b1;
      write(1'b0, 16'd50);
      while (psc1 != 16'd50 && n < 40) begin
        tick();
        n++;
        if (!wrst) rst_lo++;
        if (cfg_err) errs++;
      end
      tick();
      if (!wrst) rst_lo++;
      if (cfg_err) errs++;
      check("tmo_psc1", 32'(psc1), 50);
      check("tmo_cycles", 32'(n), 16);
      check("tmo_wrst_pulses", 32'(rst_lo), 1);
      check("tmo_err_pulses", 32'(errs), 1);
      check("tmo_busy", 32'(busy), 0);
      wclk1 = 1'b0;
    end
`else
    write(1'b1, 16'd26);
    for (int i = 0; i < 40; i++) tick();
    check("notmo_busy", 32'(busy), 1);
    check("notmo_psc2", 32'(psc2), 24);
    check("notmo_err", 32'(cfg_err), 0);
`endif

    // Reset mid-update aborts without applying.
    write(1'b1, 16'd30);
    rst_n = 1'b0;
    wclk2 = 1'b1;
    tick();
    wclk2 = 1'b0;
    tick();
    check("midrst_psc2", 32'(psc2), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_en", 32'(en), 0);
    rst_n = 1'b1;
    tick();
    check("midrst_rel_ready", 32'(cfg_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
